// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32I/RV64I immediate generator.
// Decodes the immediate, its format and an illegal flag from a 32-bit
// instruction word and presents them one cycle later behind a valid/ready
// handshake. An output register plus one skid register give two entries of
// buffering so the block runs at full throughput under backpressure while
// in_ready stays a pure register output.
// Optional feature: define IMM_GEN_CSR_EN to decode CSR immediate forms
// (csrrwi/csrrsi/csrrci) as type Z; otherwise SYSTEM is reported illegal.

module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);

    // Immediate format codes as seen on out_type.
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_Z    = 3'd6
    } imm_type_e;

    // Major opcodes that carry (or explicitly lack) an immediate.
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [31:0]     imm_i;
    logic [31:0]     imm_s;
    logic [31:0]     imm_b;
    logic [31:0]     imm_u;
    logic [31:0]     imm_j;
    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_illegal;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // 32-bit sign-extended candidates for every format; the final stage
    // widens the selected one to XLEN.
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    // Select immediate, format and illegal flag from the opcode.
    always_comb begin
        dec_imm     = '0;
        dec_type    = IMM_NONE;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_type = IMM_I;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_imm = XLEN'(in_instr[20 +: SHAMT_W]);
                end else begin
                    dec_imm = XLEN'($signed(imm_i));
                end
            end
            OPC_LOAD, OPC_JALR: begin
                dec_type = IMM_I;
                dec_imm  = XLEN'($signed(imm_i));
            end
            OPC_STORE: begin
                dec_type = IMM_S;
                dec_imm  = XLEN'($signed(imm_s));
            end
            OPC_BRANCH: begin
                dec_type = IMM_B;
                dec_imm  = XLEN'($signed(imm_b));
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_type = IMM_U;
                dec_imm  = XLEN'($signed(imm_u));
            end
            OPC_JAL: begin
                dec_type = IMM_J;
                dec_imm  = XLEN'($signed(imm_j));
            end
            OPC_OP: begin
                dec_type = IMM_NONE;
            end
`ifdef IMM_GEN_CSR_EN
            OPC_SYSTEM: begin
                if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    dec_type = IMM_Z;
                    dec_imm  = XLEN'(in_instr[19:15]);
                end
            end
`else
            OPC_SYSTEM: begin
                dec_illegal = 1'b1;
            end
`endif
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and buffer steering
    // ------------------------------------------------------------------
    logic            in_fire;
    logic            out_free;
    logic            load_out_from_in;
    logic            load_out_from_skid;
    logic            load_skid;

    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    imm_type_e       skid_type;
    logic            skid_illegal;
    imm_type_e       out_type_q;

    assign in_fire  = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;

    // Decide which register captures which word on the coming edge. A full
    // skid always has priority so acceptance order is preserved.
    always_comb begin
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        if (skid_valid) begin
            load_out_from_skid = out_free;
        end else if (out_free) begin
            load_out_from_in = in_fire;
        end else begin
            load_skid = in_fire;
        end
    end

    // Occupancy flags; in_ready mirrors the next skid state so it never
    // depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            if (load_out_from_skid) begin
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
                in_ready   <= 1'b1;
            end else if (load_skid) begin
                skid_valid <= 1'b1;
                in_ready   <= 1'b0;
            end else if (out_free) begin
                out_valid <= load_out_from_in;
            end
        end
    end

    // Output payload register; holds its value while stalled.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_imm     <= '0;
            out_type_q  <= IMM_NONE;
            out_illegal <= 1'b0;
        end else if (load_out_from_skid) begin
            out_imm     <= skid_imm;
            out_type_q  <= skid_type;
            out_illegal <= skid_illegal;
        end else if (load_out_from_in) begin
            out_imm     <= dec_imm;
            out_type_q  <= dec_type;
            out_illegal <= dec_illegal;
        end
    end

    // Skid payload register; captures a word accepted while the output stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            skid_imm     <= '0;
            skid_type    <= IMM_NONE;
            skid_illegal <= 1'b0;
        end else if (load_skid) begin
            skid_imm     <= dec_imm;
            skid_type    <= dec_type;
            skid_illegal <= dec_illegal;
        end
    end

    assign out_type = out_type_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: self-checking bench for imm_gen_pipe.
// Drives one input stream into an XLEN=32 and an XLEN=64 instance at once
// and compares both against a queue-based reference model whose decode is
// computed arithmetically from the instruction fields.

module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] imm32;
        logic [63:0] imm64;
        int          typ;
        bit          ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = 32'h0;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_type32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_type64;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    bit   known = 1'b0;
    int   observedOut = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .SHAMT_W(5)) dut32 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_type(out_type32), .out_illegal(out_illegal32)
    );

    imm_gen_pipe #(.XLEN(64), .SHAMT_W(6)) dut64 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_type(out_type64), .out_illegal(out_illegal64)
    );

    // Reference decode built from the field rules with integer arithmetic.
    function automatic exp_t refDecode(input logic [31:0] w);
        exp_t e;
        int   sw, s, hi, op, f3;
        sw    = $signed(w);
        hi    = sw >>> 31;
        op    = int'(w & 32'h7F);
        f3    = int'((w >> 12) & 32'h7);
        s     = 0;
        e.typ = 0;
        e.ill = 1'b0;
        case (op)
            'h13, 'h03, 'h67: begin
                e.typ = 1;
                if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
                    e.imm32 = (w >> 20) & 32'h1F;
                    e.imm64 = 64'((w >> 20) & 32'h3F);
                    return e;
                end
                s = sw >>> 20;
            end
            'h23: begin
                e.typ = 2;
                s = (sw >>> 25) * 32 + int'((w >> 7) & 32'h1F);
            end
            'h63: begin
                e.typ = 3;
                s = hi * 4096 + int'((w >> 7) & 32'h1) * 2048
                  + int'((w >> 25) & 32'h3F) * 32 + int'((w >> 8) & 32'hF) * 2;
            end
            'h37, 'h17: begin
                e.typ = 4;
                s = $signed(w & 32'hFFFFF000);
            end
            'h6F: begin
                e.typ = 5;
                s = hi * 1048576 + int'((w >> 12) & 32'hFF) * 4096
                  + int'((w >> 20) & 32'h1) * 2048 + int'((w >> 21) & 32'h3FF) * 2;
            end
            'h33: begin
                e.typ = 0;
            end
            'h73: begin
`ifdef IMM_GEN_CSR_EN
                if (f3 >= 5) begin
                    e.typ = 6;
                    s = int'((w >> 15) & 32'h1F);
                end
`else
                e.ill = 1'b1;
`endif
            end
            default: e.ill = 1'b1;
        endcase
        e.imm32 = s;
        e.imm64 = longint'(s);
        return e;
    endfunction

    function automatic logic [31:0] randInstr();
        logic [6:0]  ops [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37,
                                  7'h17, 7'h6F, 7'h33, 7'h73, 7'h7F};
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 11) w[6:0] = ops[k];
        return w;
    endfunction

    // Count one comparison and report it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Check the current state, drive one cycle of inputs, advance the model.
    task automatic applyStimulus(input bit v, input logic [31:0] w, input bit ordy,
                                 input bit rstn, output bit accepted);
        bit push, pop;
        @(negedge clk);
        if (known) begin
            checkOutput("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
            checkOutput("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
            checkOutput("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
            checkOutput("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
            if (q.size() > 0) begin
                checkOutput("imm32", 64'(out_imm32), 64'(q[0].imm32));
                checkOutput("type32", 64'(out_type32), 64'(q[0].typ));
                checkOutput("ill32", 64'(out_illegal32), 64'(q[0].ill));
                checkOutput("imm64", out_imm64, q[0].imm64);
                checkOutput("type64", 64'(out_type64), 64'(q[0].typ));
                checkOutput("ill64", 64'(out_illegal64), 64'(q[0].ill));
            end
            if (out_valid32 === 1'b1 && ordy) observedOut++;
        end
        in_valid  = v;
        in_instr  = w;
        out_ready = ordy;
        reset_n   = rstn;
        push = known && v && (q.size() < 2);
        pop  = known && (q.size() > 0) && ordy;
        @(posedge clk);
        if (!rstn) begin
            q.delete();
            known    = 1'b1;
            accepted = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(refDecode(w));
            accepted = push;
        end
    endtask

    logic [31:0] dirInstr [11];
    logic [31:0] dirExp32 [11];
    logic [63:0] dirExp64 [11];
    int          dirType  [11];
    bit          dirIll   [11];

    initial begin
        bit          acc;
        int          cyc, idx, base;
        logic [31:0] words [8];

        dirInstr = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123450B7, 32'h0010006F,
                     32'h00509093, 32'h00000033, 32'h0000007F, 32'h03F09093, 32'h800000B7,
                     32'h0007D073};
        dirExp32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800,
                     32'h5, 32'h0, 32'h0, 32'h1F, 32'h80000000, 32'h0};
        dirExp64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                     64'h12345000, 64'h800, 64'h5, 64'h0, 64'h0, 64'h3F,
                     64'hFFFFFFFF80000000, 64'h0};
        dirType  = '{1, 2, 3, 4, 5, 1, 0, 0, 1, 4, 0};
        dirIll   = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
`ifdef IMM_GEN_CSR_EN
        dirExp32[10] = 32'd15;
        dirExp64[10] = 64'd15;
        dirType[10]  = 6;
        dirIll[10]   = 1'b0;
`endif

        // Reset held for two cycles with a word offered.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 32'hFFF00093, 1'b1, 1'b0, acc);
            #1;
            checkOutput("rst_valid", 64'(out_valid32), 64'd0);
            checkOutput("rst_ready", 64'(in_ready32), 64'd1);
            checkOutput("rst_imm32", 64'(out_imm32), 64'd0);
            checkOutput("rst_imm64", out_imm64, 64'd0);
            checkOutput("rst_type", 64'(out_type32), 64'd0);
            checkOutput("rst_ill", 64'(out_illegal32), 64'd0);
        end
        applyStimulus(1'b1, 32'hFFF00093, 1'b1, 1'b1, acc);
        #1;
        checkOutput("accept_after_reset", 64'(out_valid32), 64'd1);

        // Directed formats: each word must appear one cycle after acceptance.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, dirInstr[i], 1'b1, 1'b1, acc);
            #1;
            checkOutput("dir_valid", 64'(out_valid32), 64'd1);
            checkOutput("dir_imm32", 64'(out_imm32), 64'(dirExp32[i]));
            checkOutput("dir_imm64", out_imm64, dirExp64[i]);
            checkOutput("dir_type32", 64'(out_type32), 64'(dirType[i]));
            checkOutput("dir_type64", 64'(out_type64), 64'(dirType[i]));
            checkOutput("dir_ill", 64'(out_illegal32), 64'(dirIll[i]));
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, acc);

        // Backpressure: eight words back-to-back with a three-cycle stall.
        for (int i = 0; i < 8; i++) words[i] = randInstr();
        base = observedOut;
        cyc  = 0;
        idx  = 0;
        while ((idx < 8 || q.size() > 0) && cyc < 100) begin
            applyStimulus(idx < 8, (idx < 8) ? words[idx] : 32'h0,
                          !(cyc >= 2 && cyc < 5), 1'b1, acc);
            if (acc) idx++;
            cyc++;
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, acc);
        checkOutput("bp_words_out", 64'(observedOut - base), 64'd8);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom % 4) != 0, randInstr(), ($urandom % 3) != 0, 1'b1, acc);
        end
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, acc);
            cyc++;
        end
        checkOutput("drain_done", 64'(q.size()), 64'd0);

        // Reset with both registers full discards both words.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, randInstr(), 1'b0, 1'b1, acc);
        end
        #1;
        checkOutput("full_valid", 64'(out_valid32), 64'd1);
        checkOutput("full_ready", 64'(in_ready32), 64'd0);
        applyStimulus(1'b1, randInstr(), 1'b1, 1'b0, acc);
        #1;
        checkOutput("midrst_valid", 64'(out_valid32), 64'd0);
        checkOutput("midrst_ready", 64'(in_ready32), 64'd1);
        checkOutput("midrst_valid64", 64'(out_valid64), 64'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
